fixedpoint_sin_arbiter: RTL and testbench
=========================================

# fixedpoint_sin_arbiter

Round-robin scheduler that lets NREQ independent requesters share one `comb_FixedPointSin` datapath. Each accepted operand is evaluated in the cycle it is accepted. The result, its saturation flags and the requester index are captured in a one-entry output register with a valid/ready handshake. The block sits between the requesting units (oscillators, rotators, test stimulus) and downstream consumers, and it owns all sequencing of the shared sine unit.

## Interface
- `NREQ`, default 4: number of requesters, range 2..16.
- `WII`, default 4: input integer bits, signed, including sign.
- `WIF`, default 12: input fraction bits.
- `WOI`, default 2: output integer bits, signed, including sign.
- `WOF`, default 12: output fraction bits.
- `ROOF`, default 1: passed to the sine unit; saturate on overflow.
- `ROUND`, default 1: passed to the sine unit; round to nearest.
- Derived constants: `WIN=WII+WIF`, `WOUT=WOI+WOF`, `WID=(NREQ>1)?$clog2(NREQ):1`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit set.
- `req_in`  in  NREQ*WIN  packed operands; requester i occupies `[i*WIN +: WIN]`.
- `out_valid`  out  1  result register holds a result.
- `out_ready`  in  1  consumer accepts the result.
- `out_sin`  out  WOUT  sine result, signed fixed point.
- `out_upflow`  out  1  upflow flag of the result.
- `out_downflow`  out  1  downflow flag of the result.
- `out_id`  out  WID  index of the requester that issued the result.

## Operation
- `can_issue = !out_valid || out_ready`.
- Grant rule:
  - When `can_issue` is high, grant the first i with `req_valid[i]=1`, scanning from `ptr` upward modulo NREQ.
  - `req_ready` is one-hot at the granted index, or zero when no request is pending or `can_issue` is low.
  - `req_ready` is combinational from `req_valid`, `ptr`, `out_valid` and `out_ready`. It never depends on `req_in`.
- Issue:
  - The granted operand is muxed onto the sine unit input, and the sine unit outputs are registered at the same edge.
  - When no grant occurs, the mux selects requester `ptr`. That value is don't-care and is not captured.
- Pointer: on a grant to index g, `ptr <= (g==NREQ-1) ? 0 : g+1`. With no grant, `ptr` holds.
- State machine, tracked by `out_valid`:
  - EMPTY→FULL on a grant.
  - FULL→FULL on a grant while `out_ready=1`. The register is overwritten with no bubble.
  - FULL→EMPTY when `out_ready=1` and there is no grant.
  - FULL holds when `out_ready=0`. All `out_*` are stable and `req_ready=0`.
- A requester must hold `req_valid` and `req_in` stable until it sees `req_ready`.
- Arithmetic: no width change beyond the sine unit. `out_sin` is the unit's WOUT-bit two's-complement output, unmodified.

## Timing
- Latency: one cycle from the accepting edge to `out_valid=1`. Throughput is one result per cycle when `out_ready` is held high.
- Reset values: `out_valid=0`, `out_sin=0`, `out_upflow=0`, `out_downflow=0`, `out_id=0`, `ptr=0`. `req_ready` is 0 in the reset cycle.
- Reset mid-operation: any held result is discarded, and no result is emitted for a request granted in the reset cycle.
- Simultaneous consume and grant: the new result replaces the old one at the same edge, and `out_valid` stays 1.
- Fairness: with all requesters continuously valid and `out_ready=1`, grants cycle 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 grants.

## Structure
- Shared package `fixedpoint_pkg` holds the `WID` calculation function and a packed typedef `sin_result_t` {sin, upflow, downflow, id}. Widths are supplied via a parameterized typedef in the instantiating module.
- Sub-module `rr_arbiter`: a combinational round-robin grant with inputs `req`, `ptr`, `en`, and outputs `gnt` (one-hot) and `gnt_idx`. It is reused later for other shared fixed-point units.
- The existing `comb_FixedPointSin` is instantiated once, with parameters passed through.

## Test plan
- Reset, then NREQ=4; requester 0 sends `0x1000` (1.0) with `out_ready=1` → `req_ready=4'b0001`; next cycle `out_valid=1`, `out_sin=0x0D77`, `out_id=0`, flags 0.
- Requesters 0..3 all valid with `0x0000` / `0xF000` / `0x1000` / `0x0000` and `out_ready=1` → ids 0,1,2,3,0 on consecutive cycles, sines 0 / `0x3289` / `0x0D77` / 0.
- Result FULL with `out_ready=0` for 3 cycles while all are valid → `out_*` stable, `req_ready=0`; on `out_ready=1` the next id follows the last grant.
- Only requester 2 continuously valid → back-to-back grants every cycle, `ptr` alternating to 3 then wrapping to search from 3, `out_id` always 2.
- Assert `rst` while FULL with a pending grant → next cycle `out_valid=0`, `ptr=0`, and the first post-reset grant goes to the lowest valid index.
- Random `req_valid` and `out_ready` for 10k cycles, checked against a scoreboard using real `sin` → every accepted operand is returned exactly once, in order, with the correct id and `req_ready` one-hot.

Source files
------------

// File: rtl/fixedpoint_pkg.sv
// fixedpoint_pkg: shared types, width helper and Q30 constants for the fixed-point sine arbiter
package fixedpoint_pkg;
   typedef enum logic {EMPTY, FULL} out_state_t;
   function automatic int wid_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int QF = 30;
   localparam logic signed [63:0] Q_ONE  = 64'sd1 <<< QF;
   localparam logic signed [63:0] Q_HALF = 64'sd1 <<< (QF - 1);
   localparam logic signed [63:0] Q_QTR  = 64'sd1 <<< (QF - 2);
   localparam logic signed [63:0] Q_3QTR = 64'sd3 <<< (QF - 2);
   localparam logic signed [63:0] Q_INV2PI = 64'sd170891319;
   localparam logic signed [63:0] Q_TWOPI  = 64'sd6746518852;
   localparam logic signed [63:0] Q_C3 = 64'sd178956971;
   localparam logic signed [63:0] Q_C5 = 64'sd8947849;
   localparam logic signed [63:0] Q_C7 = 64'sd213044;
   localparam logic signed [63:0] Q_C9 = 64'sd2959;
endpackage

// File: rtl/comb_FixedPointSin.sv
// comb_FixedPointSin: combinational sine of a signed fixed-point angle in radians
// Reduces to a quarter turn in Q30, then a degree-9 odd Taylor polynomial.
module comb_FixedPointSin import fixedpoint_pkg::*; #(
   parameter int WII   = 4,
   parameter int WIF   = 12,
   parameter int WOI   = 2,
   parameter int WOF   = 12,
   parameter int ROOF  = 1,
   parameter int ROUND = 1
) (
   input  logic [WII+WIF-1:0] in,
   output logic [WOI+WOF-1:0] out,
   output logic               upflow,
   output logic               downflow
);
   localparam int WOUT = WOI + WOF;
   localparam logic signed [63:0] OMAX = (64'sd1 <<< (WOUT - 1)) - 64'sd1;
   localparam logic signed [63:0] OMIN = -(64'sd1 <<< (WOUT - 1));
   localparam logic signed [63:0] RND  = (ROUND != 0) ? (64'sd1 <<< (QF - WOF - 1)) : 64'sd0;
   logic signed [63:0] xs, t, f, u, a, a2, p, s, r, sat;
   always_comb begin
      xs = 64'(signed'(in)) <<< (QF - WIF);
      t = (xs * Q_INV2PI) >>> QF;
      f = t & (Q_ONE - 64'sd1);
      u = (f < Q_QTR) ? f : (f < Q_3QTR) ? Q_HALF - f : f - Q_ONE;
      a = (u * Q_TWOPI) >>> QF;
      a2 = (a * a) >>> QF;
      p = Q_C7 - ((a2 * Q_C9) >>> QF);
      p = Q_C5 - ((a2 * p) >>> QF);
      p = Q_C3 - ((a2 * p) >>> QF);
      p = Q_ONE - ((a2 * p) >>> QF);
      s = (a * p) >>> QF;
      r = (s + RND) >>> (QF - WOF);
      upflow = r > OMAX;
      downflow = r < OMIN;
      sat = (upflow && ROOF != 0) ? OMAX : (downflow && ROOF != 0) ? OMIN : r;
      out = WOUT'(sat);
   end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant scanning upward from ptr, one-hot gnt plus index
module rr_arbiter import fixedpoint_pkg::*; #(
   parameter int N = 4,
   parameter int W = wid_f(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   input  logic         en,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_idx
);
   logic         found;
   logic [W-1:0] idx;
   always_comb begin
      found = 1'b0;
      idx = ptr;
      gnt_idx = ptr;
      for (int k = 0; k < N; k++) begin
         idx = W'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found = 1'b1;
            gnt_idx = idx;
         end
      end
      gnt = (en && found) ? N'(1) << gnt_idx : '0;
   end
endmodule

// File: rtl/fixedpoint_sin_arbiter.sv
// fixedpoint_sin_arbiter: round-robin sharing of one comb_FixedPointSin among NREQ requesters
// The one-entry result register doubles as the EMPTY/FULL state.
module fixedpoint_sin_arbiter import fixedpoint_pkg::*; #(
   parameter int NREQ  = 4,
   parameter int WII   = 4,
   parameter int WIF   = 12,
   parameter int WOI   = 2,
   parameter int WOF   = 12,
   parameter int ROOF  = 1,
   parameter int ROUND = 1,
   localparam int WIN  = WII + WIF,
   localparam int WOUT = WOI + WOF,
   localparam int WID  = wid_f(NREQ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*WIN-1:0] req_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WOUT-1:0]     out_sin,
   output logic                out_upflow,
   output logic                out_downflow,
   output logic [WID-1:0]      out_id
);
   typedef struct packed {
      logic [WOUT-1:0] sin;
      logic            upflow;
      logic            downflow;
      logic [WID-1:0]  id;
   } sin_result_t;
   out_state_t      state, state_nxt;
   sin_result_t     res, res_nxt;
   logic [WID-1:0]  ptr, gnt_idx;
   logic [WIN-1:0]  ops [NREQ];
   logic [WOUT-1:0] s_sin;
   logic            s_up, s_dn, can_issue, granted;
   for (genvar i = 0; i < NREQ; i++) begin : g_ops
      assign ops[i] = req_in[i*WIN +: WIN];
   end
   assign can_issue = state == EMPTY || out_ready;
   rr_arbiter #(.N(NREQ), .W(WID)) u_arb (
      .req(req_valid),
      .ptr(ptr),
      .en(can_issue && !rst),
      .gnt(req_ready),
      .gnt_idx(gnt_idx)
   );
   assign granted = |req_ready;
   comb_FixedPointSin #(
      .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF), .ROOF(ROOF), .ROUND(ROUND)
   ) u_sin (
      .in(ops[gnt_idx]),
      .out(s_sin),
      .upflow(s_up),
      .downflow(s_dn)
   );
   assign res_nxt = {s_sin, s_up, s_dn, gnt_idx};
   always_comb begin
      state_nxt = state;
      if (granted) state_nxt = FULL;
      else if (out_ready) state_nxt = EMPTY;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         ptr <= '0;
         res <= '0;
      end else begin
         state <= state_nxt;
         if (granted) begin
            res <= res_nxt;
            ptr <= (gnt_idx == WID'(NREQ - 1)) ? '0 : gnt_idx + WID'(1);
         end
      end
   end
   assign out_valid = state == FULL;
   assign out_sin = res.sin;
   assign out_upflow = res.upflow;
   assign out_downflow = res.downflow;
   assign out_id = res.id;
endmodule

// File: tb/tb_fixedpoint_sin_arbiter.sv
// tb_fixedpoint_sin_arbiter: directed steps plus a randomized scoreboard run for the sine arbiter
module tb_fixedpoint_sin_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid, req_ready;
   logic [63:0] req_in;
   logic        out_valid, out_ready, out_upflow, out_downflow;
   logic [13:0] out_sin;
   logic [1:0]  out_id;
   int checks = 0;
   int errors = 0;
   logic [3:0]  exp_g;
   logic        mv;
   logic [1:0]  mid, mptr;
   logic [15:0] mop;
   int          d;
   logic [13:0] ids_sin [4];
   logic [1:0]  ids [5];

   fixedpoint_sin_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_in(req_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_sin(out_sin),
      .out_upflow(out_upflow), .out_downflow(out_downflow), .out_id(out_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sin_exp(input logic [15:0] op);
      real x;
      x = real'($signed(op)) / 4096.0;
      return int'($floor($sin(x) * 4096.0 + 0.5));
   endfunction

   initial begin
      rst = 1'b1; req_valid = 4'hF; req_in = '0; out_ready = 1'b1;
      tick(); tick();
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_sin", 32'(out_sin), 32'h0);
      chk("rst_id", 32'(out_id), 32'h0);
      chk("rst_flags", {30'd0, out_upflow, out_downflow}, 32'h0);
      // single request from requester 0 with 1.0 rad
      rst = 1'b0; req_valid = 4'b0001; req_in[15:0] = 16'h1000;
      #1 chk("one_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b0000;
      chk("one_valid", 32'(out_valid), 32'h1);
      chk("one_sin", 32'(out_sin), 32'h0D77);
      chk("one_id", 32'(out_id), 32'h0);
      chk("one_flags", {30'd0, out_upflow, out_downflow}, 32'h0);
      #1 chk("idle_ready", 32'(req_ready), 32'h0);
      // all four valid after a fresh reset
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst2_valid", 32'(out_valid), 32'h0);
      req_in = {16'h0000, 16'h1000, 16'hF000, 16'h0000};
      req_valid = 4'b1111;
      ids_sin[0] = 14'h0000; ids_sin[1] = 14'h3289; ids_sin[2] = 14'h0D77; ids_sin[3] = 14'h0000;
      ids[0] = 2'd0; ids[1] = 2'd1; ids[2] = 2'd2; ids[3] = 2'd3; ids[4] = 2'd0;
      for (int n = 0; n < 5; n++) begin
         #1 chk("rr_ready", 32'(req_ready), 32'(4'b0001 << ids[n]));
         tick();
         chk("rr_id", 32'(out_id), 32'(ids[n]));
         chk("rr_sin", 32'(out_sin), 32'(ids_sin[ids[n]]));
      end
      // stall with a full register
      out_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         #1 chk("stall_ready", 32'(req_ready), 32'h0);
         tick();
         chk("stall_valid", 32'(out_valid), 32'h1);
         chk("stall_id", 32'(out_id), 32'h0);
         chk("stall_sin", 32'(out_sin), 32'h0);
      end
      out_ready = 1'b1;
      #1 chk("resume_ready", 32'(req_ready), 32'h2);
      tick();
      chk("resume_id", 32'(out_id), 32'h1);
      chk("resume_sin", 32'(out_sin), 32'h3289);
      // only requester 2: back-to-back grants across the pointer wrap
      req_valid = 4'b0100;
      for (int n = 0; n < 4; n++) begin
         #1 chk("solo_ready", 32'(req_ready), 32'h4);
         tick();
         chk("solo_valid", 32'(out_valid), 32'h1);
         chk("solo_id", 32'(out_id), 32'h2);
         chk("solo_sin", 32'(out_sin), 32'h0D77);
      end
      // reset while full with a pending grant
      req_valid = 4'b1111; rst = 1'b1;
      #1 chk("rstmid_ready", 32'(req_ready), 32'h0);
      tick();
      rst = 1'b0;
      chk("rstmid_valid", 32'(out_valid), 32'h0);
      chk("rstmid_id", 32'(out_id), 32'h0);
      req_valid = 4'b1010;
      #1 chk("post_rst_ready", 32'(req_ready), 32'h2);
      tick();
      chk("post_rst_id", 32'(out_id), 32'h1);
      req_valid = 4'b0001;
      #1 chk("wrap_ready", 32'(req_ready), 32'h1);
      tick();
      chk("wrap_id", 32'(out_id), 32'h0);
      req_valid = 4'b0000;
      tick();
      chk("drain_valid", 32'(out_valid), 32'h0);
      // randomized run against a scoreboard
      rst = 1'b1; tick(); rst = 1'b0;
      mv = 1'b0; mptr = 2'd0; mid = 2'd0; mop = '0; exp_g = '0;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 4; i++)
            if (!req_valid[i] || exp_g[i]) begin
               req_valid[i] = $urandom_range(0, 2) != 0;
               req_in[i*16 +: 16] = 16'($urandom);
            end
         out_ready = $urandom_range(0, 3) != 0;
         #1;
         exp_g = '0;
         if (!mv || out_ready)
            for (int k = 0; k < 4; k++) begin
               logic [1:0] j;
               j = 2'(int'(mptr) + k);
               if (exp_g == 4'b0000 && req_valid[j]) begin
                  exp_g = 4'b0001 << j;
                  mid = j;
                  mop = req_in[j*16 +: 16];
               end
            end
         chk("rnd_ready", 32'(req_ready), 32'(exp_g));
         if (exp_g != 4'b0000) begin
            mv = 1'b1;
            mptr = mid + 2'd1;
         end else if (out_ready) mv = 1'b0;
         tick();
         chk("rnd_valid", 32'(out_valid), 32'(mv));
         if (mv) begin
            chk("rnd_id", 32'(out_id), 32'(mid));
            chk("rnd_flags", {30'd0, out_upflow, out_downflow}, 32'h0);
            d = int'($signed(out_sin)) - sin_exp(mop);
            checks++;
            assert (d >= -1 && d <= 1) else begin
               errors++;
               $error("FAIL rnd_sin observed %h expected %0d for operand %h", out_sin, sin_exp(mop), mop);
            end
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
